// File: rtl/bip_pkg.sv
// Shared constants for the BIP datapath and the control unit's decoder.
package bip_pkg;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 11;
   localparam int DEPTH  = 1 << ADDR_W;

   // Accumulator source encodings; 2'b11 is reserved and holds the accumulator.
   localparam logic [1:0] SEL_A_MEM = 2'b00;
   localparam logic [1:0] SEL_A_IMM = 2'b01;
   localparam logic [1:0] SEL_A_ALU = 2'b10;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/bip_datapath_data_ram.sv
// Single-port data memory: synchronous write, combinational read gated by re.
module data_ram #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 11,
   parameter int DEPTH  = 2048
) (
   input  logic              clk,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Write port; contents are never cleared, so no reset here.
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   // Read port returns the pre-edge contents, giving read-before-write on a shared address.
   always_comb begin
      rdata = '0;
      if (re) rdata = mem[addr];
   end

endmodule

// File: rtl/bip_datapath.sv
// Accumulator datapath for the BIP processor: sign extension, add/sub ALU,
// accumulator source mux, sticky overflow flag and the data RAM.
module bip_datapath
   import bip_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        sel_a,
   input  logic              sel_b,
   input  logic              op,
   input  logic              wr_acc,
   input  logic              wr_ram,
   input  logic              rd_ram,
   input  logic [ADDR_W-1:0] operand,
   output logic [DATA_W-1:0] acc,
   output logic              ovf,
   output logic [DATA_W-1:0] mem_rdata
);

   logic [DATA_W-1:0] imm;
   logic [DATA_W-1:0] alu_b;
   logic [DATA_W-1:0] alu_res;
   logic              alu_ovf;
   logic              ram_we;

   // Writes are blocked while reset is held so a stray wr_ram cannot corrupt memory.
   assign ram_we = wr_ram & ~reset;

   data_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_data_ram (
      .clk   (clk),
      .we    (ram_we),
      .re    (rd_ram),
      .addr  (operand),
      .wdata (acc),
      .rdata (mem_rdata)
   );

   // Immediate sign extension, ALU and signed-overflow detection.
   always_comb begin
      imm     = {{(DATA_W-ADDR_W){operand[ADDR_W-1]}}, operand};
      alu_b   = sel_b ? imm : mem_rdata;
      alu_res = (op == OP_SUB) ? (acc - alu_b) : (acc + alu_b);
      if (op == OP_SUB)
         alu_ovf = (acc[DATA_W-1] != alu_b[DATA_W-1]) && (alu_res[DATA_W-1] != acc[DATA_W-1]);
      else
         alu_ovf = (acc[DATA_W-1] == alu_b[DATA_W-1]) && (alu_res[DATA_W-1] != acc[DATA_W-1]);
   end

   // Accumulator load and sticky overflow; the reserved source leaves both untouched.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc <= '0;
         ovf <= 1'b0;
      end else if (wr_acc) begin
         case (sel_a)
            SEL_A_MEM: acc <= mem_rdata;
            SEL_A_IMM: acc <= imm;
            SEL_A_ALU: begin
               acc <= alu_res;
               if (alu_ovf) ovf <= 1'b1;
            end
            default:   acc <= acc;
         endcase
      end
   end

endmodule

// File: tb/tb_bip_datapath.sv
// Bench for bip_datapath: directed scenarios plus random instructions, all
// checked against an integer-arithmetic reference model.
module tb_bip_datapath;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  sel_a = 2'b00;
   logic        sel_b = 1'b0;
   logic        op = 1'b0;
   logic        wr_acc = 1'b0;
   logic        wr_ram = 1'b0;
   logic        rd_ram = 1'b0;
   logic [10:0] operand = '0;
   logic [15:0] acc;
   logic        ovf;
   logic [15:0] mem_rdata;

   int total = 0;
   int bad = 0;

   // reference model state
   int acc_m = 0;
   int ovf_m = 0;
   int ram_m [2048];

   always #5 clk = ~clk;

   bip_datapath dut (
      .clk       (clk),
      .reset     (reset),
      .sel_a     (sel_a),
      .sel_b     (sel_b),
      .op        (op),
      .wr_acc    (wr_acc),
      .wr_ram    (wr_ram),
      .rd_ram    (rd_ram),
      .operand   (operand),
      .acc       (acc),
      .ovf       (ovf),
      .mem_rdata (mem_rdata)
   );

   function automatic int to_signed16(input int x);
      return (x >= 32768) ? x - 65536 : x;
   endfunction

   function automatic int imm_value(input int opnd);
      return (opnd >= 1024) ? opnd - 2048 : opnd;
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input int exp);
      logic [15:0] e;
      e = 16'(exp);
      total++;
      assert (obs === e) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
   endtask

   // One instruction: drive after the falling edge, check read data before the
   // rising edge, then check the architectural state after it.
   task automatic step(input logic [1:0] sa, input logic sb, input logic o,
                       input logic wa, input logic wr, input logic rr,
                       input int opnd);
      int exp_rd, imm_s, b_s, res, old_acc;
      @(negedge clk);
      sel_a = sa; sel_b = sb; op = o; wr_acc = wa; wr_ram = wr; rd_ram = rr;
      operand = 11'(opnd);
      exp_rd = rr ? ram_m[opnd] : 0;
      #1;
      chk("mem_rdata", mem_rdata, exp_rd);
      imm_s   = imm_value(opnd);
      b_s     = sb ? imm_s : to_signed16(exp_rd);
      res     = o ? to_signed16(acc_m) - b_s : to_signed16(acc_m) + b_s;
      old_acc = acc_m;
      if (wa) begin
         case (sa)
            2'd0: acc_m = exp_rd;
            2'd1: acc_m = imm_s & 16'hFFFF;
            2'd2: begin
               acc_m = res & 16'hFFFF;
               if (res > 32767 || res < -32768) ovf_m = 1;
            end
            default: ;
         endcase
      end
      if (wr) ram_m[opnd] = old_acc;
      @(posedge clk);
      #1;
      chk("acc", acc, acc_m);
      chk("ovf", {15'd0, ovf}, ovf_m);
   endtask

   task automatic idle();
      step(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
   endtask

   // Build acc = 0x3FF*4 + 0x115 on top of its current value.
   task automatic add_0x1111();
      for (int k = 0; k < 4; k++) step(2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 11'h3FF);
      step(2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 11'h115);
   endtask

   initial begin
      // reset state
      #1;
      chk("reset_acc", acc, 0);
      chk("reset_ovf", {15'd0, ovf}, 0);
      @(negedge clk);
      reset = 1'b0;

      // fill every RAM word so later reads are defined: RAM[i] <= old acc, acc <= imm(i)
      for (int i = 0; i < 2048; i++) step(2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, i);

      // immediate sign extension
      step(2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 11'h3FF);
      chk("imm_pos", acc, 16'h03FF);
      step(2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 11'h400);
      chk("imm_neg", acc, 16'hFC00);

      // store then load, neighbour untouched
      step(2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 11'h0AB);
      step(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5);
      step(2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5);
      chk("load_acc", acc, 16'h00AB);
      step(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6);

      // add/sub immediate
      step(2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10);
      step(2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 11'h7FB);
      chk("add_neg_imm", acc, 5);
      step(2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 7);
      chk("sub_imm", acc, 16'hFFFE);

      // reserved sel_a holds acc
      step(2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1);
      chk("sel_a_rsvd", acc, 16'hFFFE);

      // overflow: 0 - (-1024)*31 + 1023 = 0x7FFF, then +1
      step(2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
      for (int k = 0; k < 31; k++) step(2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 11'h400);
      step(2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 11'h3FF);
      chk("pre_ovf_acc", acc, 16'h7FFF);
      chk("pre_ovf_flag", {15'd0, ovf}, 0);
      step(2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1);
      chk("ovf_acc", acc, 16'h8000);
      chk("ovf_set", {15'd0, ovf}, 1);
      step(2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
      chk("ovf_sticky", {15'd0, ovf}, 1);

      // same-address write and read in one cycle
      add_0x1111();
      chk("acc_1111", acc, 16'h1111);
      step(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3);
      add_0x1111();
      chk("acc_2222", acc, 16'h2222);
      step(2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3);
      chk("rw_same_acc", acc, 16'h1111);
      step(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3);
      chk("rw_same_ram", mem_rdata, 16'h2222);

      // mid-cycle asynchronous reset with acc=0x1234 and a pending RAM write
      step(2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 11'h3FF);
      for (int k = 0; k < 3; k++) step(2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 11'h3FF);
      step(2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 11'h238);
      chk("acc_1234", acc, 16'h1234);
      @(negedge clk);
      sel_a = 2'b01; wr_acc = 1'b1; wr_ram = 1'b1; rd_ram = 1'b0; operand = 11'd3;
      reset = 1'b1;
      #1;
      chk("async_rst_acc", acc, 0);
      chk("async_rst_ovf", {15'd0, ovf}, 0);
      acc_m = 0;
      ovf_m = 0;
      @(posedge clk);
      #1;
      chk("rst_hold_acc", acc, 0);
      @(negedge clk);
      reset = 1'b0;
      wr_acc = 1'b0; wr_ram = 1'b0;
      step(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3);
      chk("ram_kept_rst", mem_rdata, 16'h2222);

      // random instructions against the model
      for (int i = 0; i < 400; i++) begin
         step(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), int'($urandom_range(0, 2047)));
      end
      idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
